// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO.
// Synchronizes the Gray write pointer into rclk, keeps binary/Gray read
// pointers, generates the empty flag and a conservative fill level, and
// moves memory read data into a one-entry valid/ready output register.
module fifo_read_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    // Two-flop synchronizer stages for the foreign-domain write pointer.
    logic [ADDRSIZE:0] rq1_wptr;
    logic [ADDRSIZE:0] rq2_wptr;

    // Read pointer state and its next-state terms.
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] rlevel_next;
    logic              rempty_next;
    logic              rinc;

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pop whenever memory holds a word and the output register is free or
    // being drained this cycle; this is the only memory read strobe.
    always_comb begin
        rinc        = !rempty && (!dout_valid || dout_ready);
        rbinnext    = rbin + {{ADDRSIZE{1'b0}}, rinc};
        rgraynext   = bin2gray(rbinnext);
        // Full-width Gray compare keeps laps apart (MSB included).
        rempty_next = (rgraynext == rq2_wptr);
        // Based on the synchronized pointer, so it can only understate.
        rlevel_next = gray2bin(rq2_wptr) - rbinnext;
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    // --- stage: write pointer synchronizer (wclk -> rclk) ---
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

    // --- stage: read pointers, empty flag and fill level ---
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            rlevel <= '0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= rempty_next;
            rlevel <= rlevel_next;
        end
    end

    // --- stage: output register; pop reloads it, accept alone empties it ---
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (rinc) begin
            dout       <= rdata;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: memory and write side are modelled
// here; delivered words are checked against a queue of everything written.
module tb_fifo_read_ctrl;

    logic       clk = 1'b0;
    logic       rrst_n = 1'b1;
    logic [4:0] wptr = '0;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [4:0] rlevel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;

    logic [7:0] mem [16];
    logic [7:0] q [$];
    int total = 0;
    int bad = 0;
    int wbin = 0;
    int acc = 0;

    assign rdata = mem[raddr];

    fifo_read_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk(clk), .rrst_n(rrst_n), .wptr(wptr), .rdata(rdata),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .rlevel(rlevel),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        logic [7:0] wdata;
        bit         rdy;
        bit         e_empty;
        bit         e_valid;
        logic [7:0] e_dout;
        int         e_level;
        int         e_raddr;
        int         e_rptr;
    } vec_t;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    function automatic int g2b(input logic [4:0] g);
        logic [5:0] t;
        t = '0;
        for (int i = 4; i >= 0; i--) t[i] = t[i+1] ^ g[i];
        return int'(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wbin % 16] = d;
        q.push_back(d);
        wbin++;
        wptr = gray5(wbin);
    endtask

    task automatic clear_model();
        wbin = 0;
        acc = 0;
        q.delete();
        wptr = '0;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        dout_ready = 1'b0;
        clear_model();
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    // Prefill 16 words 0x00..0x0F while reset holds the read side idle.
    task automatic prefill16();
        rrst_n = 1'b0;
        dout_ready = 1'b0;
        clear_model();
        for (int i = 0; i < 16; i++) write_word(8'(i));
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    // One consumer cycle plus the running invariants of the reference model.
    task automatic cstep(input logic rdy);
        logic [7:0] exp_d;
        logic       stall;
        logic [7:0] held;
        int         inflight;
        dout_ready = rdy;
        stall = dout_valid && !rdy;
        held = dout;
        if (dout_valid && rdy) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_word: got 0x%0h with nothing outstanding", dout);
            end else begin
                exp_d = q.pop_front();
                check("data", int'(dout), int'(exp_d));
                acc++;
            end
        end
        tick();
        if (stall) begin
            check("hold_valid", int'(dout_valid), 1);
            check("hold_dout", int'(dout), int'(held));
        end
        check("rptr_count", g2b(rptr), (acc + int'(dout_valid)) % 32);
        inflight = wbin - acc - int'(dout_valid);
        check("rlevel_bound", int'(int'(rlevel) <= inflight && rlevel <= 5'd16), 1);
        if (!rempty) check("empty_safe", int'(inflight >= 1), 1);
    endtask

    task automatic cycle(input bit wr, input logic [7:0] d, input logic rdy);
        if (wr) write_word(d);
        cstep(rdy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        bit   seen;
        int   prev_raddr;
        int   prev_msb;
        int   wraps;
        int   toggles;

        tbl[0]  = '{1, 8'hA5, 1, 1, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0};
        tbl[2]  = '{0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0};
        tbl[3]  = '{0, 8'h00, 1, 1, 1, 8'hA5, 0, 1, 1};
        tbl[4]  = '{0, 8'h00, 1, 1, 0, 8'hA5, 0, 1, 1};
        tbl[5]  = '{1, 8'h3C, 0, 1, 0, 8'hA5, 0, 1, 1};
        tbl[6]  = '{1, 8'h7E, 0, 1, 0, 8'hA5, 0, 1, 1};
        tbl[7]  = '{0, 8'h00, 0, 0, 0, 8'hA5, 1, 1, 1};
        tbl[8]  = '{0, 8'h00, 0, 0, 1, 8'h3C, 1, 2, 3};
        tbl[9]  = '{0, 8'h00, 0, 0, 1, 8'h3C, 1, 2, 3};
        tbl[10] = '{0, 8'h00, 1, 1, 1, 8'h7E, 0, 3, 2};
        tbl[11] = '{0, 8'h00, 1, 1, 0, 8'h7E, 0, 3, 2};

        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state, asserted asynchronously before any clock edge.
        #2 rrst_n = 1'b0;
        #1;
        check("rst_rempty", int'(rempty), 1);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_rptr", int'(rptr), 0);
        check("rst_rlevel", int'(rlevel), 0);
        check("rst_dout", int'(dout), 0);
        tick();
        tick();
        rrst_n = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_raddr", int'(raddr), 0);
            check("idle_valid", int'(dout_valid), 0);
        end

        // Single word latency and backpressure, cycle by cycle.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) write_word(tbl[i].wdata);
            dout_ready = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d_rempty", i), int'(rempty), int'(tbl[i].e_empty));
            check($sformatf("vec%0d_valid", i), int'(dout_valid), int'(tbl[i].e_valid));
            check($sformatf("vec%0d_dout", i), int'(dout), int'(tbl[i].e_dout));
            check($sformatf("vec%0d_rlevel", i), int'(rlevel), tbl[i].e_level);
            check($sformatf("vec%0d_raddr", i), int'(raddr), tbl[i].e_raddr);
            check($sformatf("vec%0d_rptr", i), int'(rptr), tbl[i].e_rptr);
        end

        // Full memory drained at one word per clock.
        prefill16();
        seen = 0;
        for (int n = 0; n < 10 && !dout_valid; n++) begin
            if (!rempty && !seen) begin
                check("full_rlevel", int'(rlevel), 16);
                seen = 1;
            end
            cstep(1'b1);
        end
        check("full_level_seen", int'(seen), 1);
        for (int i = 0; i < 16; i++) begin
            check("burst_valid", int'(dout_valid), 1);
            check("burst_rlevel", int'(rlevel), 15 - i);
            cstep(1'b1);
        end
        check("burst_end_valid", int'(dout_valid), 0);
        check("burst_end_rempty", int'(rempty), 1);
        check("burst_end_rptr", int'(rptr), 24);
        check("burst_end_raddr", int'(raddr), 0);

        // Second lap: stall output, fill memory so read and write are 16 apart.
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 4; i++) cstep(1'b0);
        check("lap_rempty", int'(rempty), 0);
        check("lap_rlevel", int'(rlevel), 16);
        check("lap_dout", int'(dout), 8'h40);
        check("lap_rptr_msb", int'(rptr[4]), 1);
        for (int n = 0; n < 60 && q.size() > 0; n++) cstep(1'b1);
        check("lap_drained", q.size(), 0);

        // Full memory drained under a 1,0,0,1 ready pattern.
        prefill16();
        for (int n = 0; n < 200 && q.size() > 0; n++) cstep((n % 4 == 0) || (n % 4 == 3));
        check("bp_drained", q.size(), 0);
        check("bp_rptr", int'(rptr), 24);

        // Random streaming of 40 words across two pointer laps.
        do_reset();
        wraps = 0;
        toggles = 0;
        prev_raddr = int'(raddr);
        prev_msb = int'(rptr[4]);
        for (int n = 0; n < 3000 && !(wbin == 40 && q.size() == 0); n++) begin
            bit wr;
            wr = (wbin < 40) && ($urandom % 3 != 0) && (((wbin - g2b(rptr)) & 31) < 16);
            cycle(wr, 8'($urandom), 1'($urandom % 4 != 0));
            if (prev_raddr == 15 && raddr == 4'd0) wraps++;
            if (prev_msb != int'(rptr[4])) toggles++;
            prev_raddr = int'(raddr);
            prev_msb = int'(rptr[4]);
        end
        check("rand_drained", q.size(), 0);
        check("rand_written", wbin, 40);
        check("rand_raddr_wraps", wraps, 2);
        check("rand_msb_toggles", toggles, 2);

        // Reset in the middle of a burst with 5 words queued.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 4; i++) cstep(1'b0);
        check("pre_rst_valid", int'(dout_valid), 1);
        #2 rrst_n = 1'b0;
        #1;
        check("mid_rst_rempty", int'(rempty), 1);
        check("mid_rst_valid", int'(dout_valid), 0);
        check("mid_rst_dout", int'(dout), 0);
        check("mid_rst_rptr", int'(rptr), 0);
        check("mid_rst_rlevel", int'(rlevel), 0);
        check("mid_rst_raddr", int'(raddr), 0);
        clear_model();
        tick();
        rrst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cstep(1'b1);
            check("post_rst_valid", int'(dout_valid), 0);
            check("post_rst_rempty", int'(rempty), 1);
        end
        cycle(1'b1, 8'h99, 1'b1);
        for (int n = 0; n < 20 && q.size() > 0; n++) cstep(1'b1);
        check("post_rst_fresh_word", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
